// File: rtl/regfile_pkg.sv
// Shared defaults and address-width helper for the scoreboarded register file.
package regfile_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int DEPTH_DEF = 8;

    // Address width for a register count; never narrower than one bit.
    function automatic int aw_f(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: mark sets, write clears, flush clears all; updates land on the next edge.
// No backpressure; mark beats a same-address write, flush beats both.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     ldreg,
    input  logic [aw_f(DEPTH)-1:0]   drmux,
    input  logic                     mark,
    input  logic [aw_f(DEPTH)-1:0]   mark_addr,
    input  logic                     flush,
    output logic [DEPTH-1:0]         busy_vec
);

    logic [DEPTH-1:0] busy_nxt;

    always_comb begin
        busy_nxt = busy_vec;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (ldreg) busy_nxt[drmux] = 1'b0;
            // Applied after the clear so a same-cycle claim survives the write.
            if (mark) busy_nxt[mark_addr] = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) busy_vec <= '0;
        else          busy_vec <= busy_nxt;
    end

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with busy scoreboard; reads are zero-latency, writes land on the edge.
// No backpressure; sr*_rdy flags reads whose producer is still in flight.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int BYPASS = 1
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     ldreg,
    input  logic [aw_f(DEPTH)-1:0]   drmux,
    input  logic [WIDTH-1:0]         bus,
    input  logic                     mark,
    input  logic [aw_f(DEPTH)-1:0]   mark_addr,
    input  logic                     flush,
    input  logic [aw_f(DEPTH)-1:0]   sr1mux,
    input  logic [aw_f(DEPTH)-1:0]   sr2input,
    output logic [WIDTH-1:0]         sr1,
    output logic [WIDTH-1:0]         sr2,
    output logic                     sr1_rdy,
    output logic                     sr2_rdy,
    output logic [DEPTH-1:0]         busy_vec
);

    logic [DEPTH-1:0][WIDTH-1:0] regs;
    logic                        wr_live;
    logic                        hit1;
    logic                        hit2;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)   regs <= '0;
        else if (ldreg) regs[drmux] <= bus;
    end

    regfile_scoreboard #(.DEPTH(DEPTH)) u_sb (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .ldreg     (ldreg),
        .drmux     (drmux),
        .mark      (mark),
        .mark_addr (mark_addr),
        .flush     (flush),
        .busy_vec  (busy_vec)
    );

    // A write held during reset is discarded, so it must not forward either.
    assign wr_live = Reset_n && ldreg && (BYPASS != 0);
    assign hit1    = wr_live && (drmux == sr1mux);
    assign hit2    = wr_live && (drmux == sr2input);

    always_comb begin
        sr1     = regs[sr1mux];
        sr1_rdy = !busy_vec[sr1mux];
        if (hit1) begin
            sr1     = bus;
            sr1_rdy = 1'b1;
        end
    end

    always_comb begin
        sr2     = regs[sr2input];
        sr2_rdy = !busy_vec[sr2input];
        if (hit2) begin
            sr2     = bus;
            sr2_rdy = 1'b1;
        end
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width of each register.
REQ-002 SHALL have parameter DEPTH, default 8, register count; power of two, 2..32.
REQ-003 SHALL have parameter BYPASS, default 1; 1 enables write-to-read forwarding.
REQ-004 SHALL have port Clk, input, 1, single clock, rising-edge active.
REQ-005 SHALL have port Reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port ldreg, input, 1, write enable.
REQ-007 SHALL have port drmux, input, AW=$clog2(DEPTH), write address.
REQ-008 SHALL have port bus, input, WIDTH, write data.
REQ-009 SHALL have port mark, input, 1, set busy bit of mark_addr.
REQ-010 SHALL have port mark_addr, input, AW, register being claimed by an in-flight producer.
REQ-011 SHALL have port flush, input, 1, synchronous clear of all busy bits.
REQ-012 SHALL have ports sr1mux and sr2input, input, AW each, read addresses.
REQ-013 SHALL have ports sr1 and sr2, output, WIDTH each, read data.
REQ-014 SHALL have ports sr1_rdy and sr2_rdy, output, 1 each; high when the read data is not pending.
REQ-015 SHALL have port busy_vec, output, DEPTH, current busy bits.

Function
REQ-016 SHALL write bus into register drmux on a rising Clk edge when ldreg=1.
REQ-017 SHALL clear busy[drmux] on that same edge when ldreg=1.
REQ-018 SHALL set busy[mark_addr] on a rising edge when mark=1.
REQ-019 SHALL give mark priority on a same-cycle ldreg and mark to one address: data is written and busy ends at 1.
REQ-020 SHALL clear every busy bit on flush=1; flush overrides mark and ldreg busy updates, and a data write still occurs.
REQ-021 SHALL drive sr1 and sr2 combinationally from the addressed register (zero-latency read).
REQ-022 SHALL, when BYPASS=1, ldreg=1 and drmux equals a read address, return bus on that port in the same cycle and assert its rdy.
REQ-023 SHALL, when BYPASS=0, return the old register value and rdy=!busy in that same case.
REQ-024 SHALL otherwise drive srN_rdy = !busy[srNaddr].
REQ-025 SHALL serve two read ports independently; identical addresses return identical data and rdy.
REQ-026 SHALL keep all outputs X-free for any address in range 0..DEPTH-1.

Reset
REQ-027 SHALL, while Reset_n=0, asynchronously clear all registers to 0 and all busy bits to 0, independent of Clk.
REQ-028 SHALL ignore ldreg, mark and flush while Reset_n=0; a write or mark pending at reset assertion is discarded.
REQ-029 SHALL output sr1=sr2=0, sr1_rdy=sr2_rdy=1 and busy_vec=0 in reset.
REQ-030 SHALL accept operations on the first rising edge after Reset_n deasserts.

Structure
REQ-031 SHALL place the WIDTH and DEPTH defaults and the AW derivation function in shared package regfile_pkg.
REQ-032 SHALL implement the busy-bit logic as sub-module regfile_scoreboard, covering set, clear, flush and priority.
REQ-033 SHALL implement data storage as a DEPTH x WIDTH packed array with generate-free indexed access.

Verification
REQ-034 Reset then write R3=16'hBEEF -> next cycle sr1mux=3 gives sr1=BEEF and sr1_rdy=1.
REQ-035 Write R5=16'h1234 with sr2input=5 in the same cycle -> BYPASS=1 gives sr2=1234; BYPASS=0 gives sr2=0000.
REQ-036 mark R2, then read R2 -> sr1_rdy=0 and busy_vec=8'h04; write R2=16'h0042 -> rdy=1 and sr1=0042.
REQ-037 Same-cycle ldreg and mark on R6 with data 16'h00FF -> R6=00FF and busy_vec[6]=1.
REQ-038 mark R1, R4 and R7, then flush -> busy_vec=0; Reset_n low mid-write of R0 -> R0=0 and all outputs at reset values.
REQ-039 Run with DEPTH=16 and WIDTH=32: write R15=32'hDEADBEEF -> read back exact; R0 is unaffected.
